// File: rtl/ipc_pkg.sv
// Shared definitions for the IPC receive path.
//   ipc_state_t  : receive FSM encoding
//   PID_NONE     : destination id meaning "no addressee"
//   FLD_*        : field slots of a queued entry; slot i occupies
//                  bits [i*DATA_WIDTH +: DATA_WIDTH], so the entry
//                  packs as {data, src, dst} with dst in the low slot.
package ipc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } ipc_state_t;

  localparam int PID_NONE     = 0;

  localparam int FLD_DST      = 0;
  localparam int FLD_SRC      = 1;
  localparam int FLD_DATA     = 2;
  localparam int ENTRY_FIELDS = 3;

  function automatic int fld_lsb(input int fld, input int width);
    return fld * width;
  endfunction

endpackage

// File: rtl/ipc_msg_receiver_if.sv
// Sender/CPU-facing signals of the IPC receiver.
//   send_*            : word staged by the sender (1-cycle send_valid pulse)
//   recv_req, cur_pid : receive request from the running process
//   recv_*            : delivery / miss pulses and held delivered word
//   busy              : receive in progress
// master = sender/CPU side, slave = receiver side.
interface ipc_msg_receiver_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  send_valid;
  logic [DATA_WIDTH-1:0] send_data;
  logic [DATA_WIDTH-1:0] send_src_pid;
  logic [DATA_WIDTH-1:0] send_dst_pid;
  logic                  recv_req;
  logic [DATA_WIDTH-1:0] cur_pid;
  logic                  recv_valid;
  logic [DATA_WIDTH-1:0] recv_data;
  logic [DATA_WIDTH-1:0] recv_src_pid;
  logic                  recv_miss;
  logic                  busy;

  modport master (
    output send_valid, send_data, send_src_pid, send_dst_pid, recv_req, cur_pid,
    input  recv_valid, recv_data, recv_src_pid, recv_miss, busy
  );

  modport slave (
    input  send_valid, send_data, send_src_pid, send_dst_pid, recv_req, cur_pid,
    output recv_valid, recv_data, recv_src_pid, recv_miss, busy
  );
endinterface

// File: rtl/ipc_msg_fifo.sv
// Synchronous FIFO holding tagged IPC entries.
//   clock, reset : system clock, synchronous active-high reset
//   push, wdata  : write request; accepted when not full, or when full
//                  and a pop happens in the same cycle
//   pop          : remove head (ignored when empty)
//   head         : entry at the read pointer (combinational)
//   count        : entries held, 0 .. 2**DEPTH_LOG2
//   full, empty  : decoded from count
module ipc_msg_fifo #(
  parameter int WIDTH      = 96,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full queue is safe.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ipc_msg_receiver.sv
// Receive side of the inter-process transfer path: queues staged words
// tagged with src/dst pid and hands the head word to the running process
// when it is the addressee.
//   clock, reset    : system clock, synchronous active-high reset
//   bus             : sender / receive-request signals (slave modport)
//   clear_overflow  : clears the sticky overflow flag
//   count           : entries queued
//   empty, full     : queue status
//   overflow        : sticky, a send to a full queue was dropped
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for recv_req; latches cur_pid and raises busy
// ST_CHECK | compares head dst with latched pid, registers hit
// ST_RESP  | hit: deliver head and pop; miss: pulse recv_miss; drop busy
module ipc_msg_receiver
  import ipc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clock,
  input  logic                reset,
  ipc_msg_receiver_if.slave   bus,
  input  logic                clear_overflow,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full,
  output logic                overflow
);

  localparam int EW = ENTRY_FIELDS * DATA_WIDTH;

  ipc_state_t            state_q;
  logic [DATA_WIDTH-1:0] pid_q;
  logic                  hit_q;
  logic                  recv_valid_q;
  logic                  recv_miss_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] recv_data_q;
  logic [DATA_WIDTH-1:0] recv_src_q;
  logic                  overflow_q;

  logic [EW-1:0]         wr_entry;
  logic [EW-1:0]         head_entry;
  logic [DATA_WIDTH-1:0] head_dst;
  logic [DATA_WIDTH-1:0] head_src;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  dst_valid;
  logic                  push;
  logic                  pop;
  logic                  drop_full;

  assign wr_entry  = {bus.send_data, bus.send_src_pid, bus.send_dst_pid};
  assign head_dst  = head_entry[fld_lsb(FLD_DST,  DATA_WIDTH) +: DATA_WIDTH];
  assign head_src  = head_entry[fld_lsb(FLD_SRC,  DATA_WIDTH) +: DATA_WIDTH];
  assign head_data = head_entry[fld_lsb(FLD_DATA, DATA_WIDTH) +: DATA_WIDTH];

  assign dst_valid = (bus.send_dst_pid != DATA_WIDTH'(PID_NONE));
  assign push      = bus.send_valid && dst_valid;
  // hit_q is only set when the queue was non-empty, so pop never underflows.
  assign pop       = (state_q == ST_RESP) && hit_q;
  assign drop_full = push && full && !pop;

  ipc_msg_fifo #(
    .WIDTH      (EW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .head  (head_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pid_q        <= '0;
      hit_q        <= 1'b0;
      recv_valid_q <= 1'b0;
      recv_miss_q  <= 1'b0;
      busy_q       <= 1'b0;
      recv_data_q  <= '0;
      recv_src_q   <= '0;
    end else begin
      recv_valid_q <= 1'b0;
      recv_miss_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.recv_req) begin
            pid_q   <= bus.cur_pid;
            busy_q  <= 1'b1;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Strict FIFO: only the head is considered, no scan past it.
          hit_q   <= !empty && (head_dst == pid_q);
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (hit_q) begin
            recv_valid_q <= 1'b1;
            recv_data_q  <= head_data;
            recv_src_q   <= head_src;
          end else begin
            recv_miss_q  <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Set has priority over clear so a same-cycle drop is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop_full) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.recv_valid   = recv_valid_q;
  assign bus.recv_miss    = recv_miss_q;
  assign bus.recv_data    = recv_data_q;
  assign bus.recv_src_pid = recv_src_q;
  assign bus.busy         = busy_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_ipc_msg_receiver.sv
module tb_ipc_msg_receiver;

  logic       clock;
  logic       reset;
  logic       clear_overflow;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    logic [31:0] src;
  } exp_t;

  exp_t sb[$];

  ipc_msg_receiver_if #(.DATA_WIDTH(32)) bus ();

  ipc_msg_receiver #(.DATA_WIDTH(32), .DEPTH_LOG2(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .clear_overflow (clear_overflow),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] s, input logic [31:0] dst);
    bus.send_valid   = 1'b1;
    bus.send_data    = d;
    bus.send_src_pid = s;
    bus.send_dst_pid = dst;
    tick();
    bus.send_valid   = 1'b0;
  endtask

  task automatic expect_resp(input logic hit, input logic [31:0] d, input logic [31:0] s);
    exp_t e;
    e.hit  = hit;
    e.data = d;
    e.src  = s;
    sb.push_back(e);
  endtask

  // Issues one receive and returns just after the response edge (req edge + 2).
  task automatic recv(input logic [31:0] pid, input logic hit, input logic [31:0] d, input logic [31:0] s);
    expect_resp(hit, d, s);
    bus.recv_req = 1'b1;
    bus.cur_pid  = pid;
    tick();
    bus.recv_req = 1'b0;
    check("busy_in_check", {31'b0, bus.busy}, 32'd1);
    check("no_early_resp", {31'b0, bus.recv_valid | bus.recv_miss}, 32'd0);
    tick();
    check("no_resp_in_check", {31'b0, bus.recv_valid | bus.recv_miss}, 32'd0);
    tick();
    check("resp_latency", {31'b0, bus.recv_valid | bus.recv_miss}, 32'd1);
  endtask

  // Scoreboard monitor: pops one expectation per response pulse.
  always @(negedge clock) begin
    if (!reset && (bus.recv_valid || bus.recv_miss)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got valid=%0b miss=%0b data=0x%0h required no response",
                 bus.recv_valid, bus.recv_miss, bus.recv_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_exclusive", {31'b0, bus.recv_valid & bus.recv_miss}, 32'd0);
        check("resp_is_hit", {31'b0, bus.recv_valid}, {31'b0, e.hit});
        if (e.hit) begin
          check("resp_data", bus.recv_data, e.data);
          check("resp_src", bus.recv_src_pid, e.src);
        end
      end
    end
  end

  initial begin
    reset            = 1'b1;
    clear_overflow   = 1'b0;
    bus.send_valid   = 1'b0;
    bus.send_data    = '0;
    bus.send_src_pid = '0;
    bus.send_dst_pid = '0;
    bus.recv_req     = 1'b0;
    bus.cur_pid      = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_recv_valid", {31'b0, bus.recv_valid}, 32'd0);
    check("rst_recv_miss", {31'b0, bus.recv_miss}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_recv_data", bus.recv_data, 32'd0);
    check("rst_recv_src", bus.recv_src_pid, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);

    // 1. single word hit
    send(32'hCAFE, 32'd1, 32'd2);
    check("t1_count_1", {29'b0, count}, 32'd1);
    recv(32'd2, 1'b1, 32'hCAFE, 32'd1);
    check("t1_count_0", {29'b0, count}, 32'd0);

    // 2. empty queue miss
    recv(32'd3, 1'b0, 32'd0, 32'd0);
    check("t2_count", {29'b0, count}, 32'd0);

    // 3. head blocking
    send(32'hA2, 32'd5, 32'd2);
    send(32'hB3, 32'd6, 32'd3);
    recv(32'd3, 1'b0, 32'd0, 32'd0);
    check("t3_count_after_miss", {29'b0, count}, 32'd2);
    recv(32'd2, 1'b1, 32'hA2, 32'd5);
    recv(32'd3, 1'b1, 32'hB3, 32'd6);
    check("t3_count_0", {29'b0, count}, 32'd0);

    // 4. overflow
    for (int i = 0; i < 5; i++) send(32'h10 + i, 32'd7, 32'd1);
    check("t4_count", {29'b0, count}, 32'd4);
    check("t4_full", {31'b0, full}, 32'd1);
    check("t4_overflow", {31'b0, overflow}, 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t4_overflow_clr", {31'b0, overflow}, 32'd0);

    // 5. push while full in the same cycle as the RESP pop
    expect_resp(1'b1, 32'h10, 32'd7);
    bus.recv_req = 1'b1;
    bus.cur_pid  = 32'd1;
    tick();
    bus.recv_req = 1'b0;
    tick();
    send(32'h20, 32'd8, 32'd1);
    check("t5_count", {29'b0, count}, 32'd4);
    check("t5_no_overflow", {31'b0, overflow}, 32'd0);
    check("t5_full", {31'b0, full}, 32'd1);
    send(32'h99, 32'd8, 32'd0);
    check("t5_dst0_count", {29'b0, count}, 32'd4);
    check("t5_dst0_no_ovf", {31'b0, overflow}, 32'd0);
    clear_overflow = 1'b1;
    send(32'h98, 32'd8, 32'd1);
    clear_overflow = 1'b0;
    check("t5_set_wins", {31'b0, overflow}, 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    recv(32'd1, 1'b1, 32'h11, 32'd7);
    recv(32'd1, 1'b1, 32'h12, 32'd7);
    recv(32'd1, 1'b1, 32'h13, 32'd7);
    recv(32'd1, 1'b1, 32'h20, 32'd8);
    check("t5_drained", {29'b0, count}, 32'd0);
    check("t5_empty", {31'b0, empty}, 32'd1);

    // 6a. reset during CHECK
    send(32'h66, 32'd9, 32'd2);
    bus.recv_req = 1'b1;
    bus.cur_pid  = 32'd2;
    tick();
    bus.recv_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_busy", {31'b0, bus.busy}, 32'd0);
    check("t6_count", {29'b0, count}, 32'd0);
    check("t6_recv_data", bus.recv_data, 32'd0);
    check("t6_recv_src", bus.recv_src_pid, 32'd0);
    tick();
    tick();
    tick();
    check("t6_no_valid", {31'b0, bus.recv_valid | bus.recv_miss}, 32'd0);

    // 6b. recv_req held while busy: exactly one response
    send(32'h44, 32'd3, 32'd4);
    send(32'h45, 32'd3, 32'd4);
    expect_resp(1'b1, 32'h44, 32'd3);
    bus.recv_req = 1'b1;
    bus.cur_pid  = 32'd4;
    tick();
    tick();
    tick();
    bus.recv_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t6_one_pop", {29'b0, count}, 32'd1);
    check("t6_idle", {31'b0, bus.busy}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
